// File: rtl/aes_pkg.sv
// Shared constants and types for the AES output serializer.
package aes_pkg;

  // Output word geometry: a 128-bit block leaves as four 32-bit words.
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int BLK_W     = WORD_W * NUM_WORDS;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  // Index of the final word of a block.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // Serializer control states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/aes_pulse_det.sv
// Rising-edge detector for the upstream completion flag.
// The history register resets to 1 so that a flag already high when reset
// releases is not mistaken for a fresh edge.
module aes_pulse_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q_reg;

  // Remember last cycle's level of din.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_q_reg <= 1'b1;
    else      din_q_reg <= din;
  end

  assign rise = din & ~din_q_reg;

endmodule

// File: rtl/aes_out_serializer.sv
// Splits each finished 128-bit AES block into four 32-bit words with a
// valid/ready handshake. One block is held at a time; a completion that
// arrives while a block is still going out is dropped and flagged, except
// when it lands exactly on the final transfer, which chains without a gap.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter bit LSW_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [BLK_W-1:0]  blk_in,
  input  logic              word_ready,
  input  logic              clr_ovf,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              word_last,
  output logic              busy,
  output logic              overflow
);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [BLK_W-1:0]   blk_reg, blk_next;
  logic               ovf_reg, ovf_next;
  logic               capture;
  logic               xfer;
  logic               last_xfer;
  logic               ovf_event;
  logic [WORD_W-1:0]  word_arr [NUM_WORDS];

  aes_pulse_det u_pulse_det (
    .clk  (clk),
    .rst  (rst),
    .din  (done),
    .rise (capture)
  );

  // Word slot gi is the gi-th word to leave, in the selected order.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    if (LSW_FIRST) begin : g_lsw
      assign word_arr[gi] = blk_reg[gi*WORD_W +: WORD_W];
    end else begin : g_msw
      assign word_arr[gi] = blk_reg[(NUM_WORDS-1-gi)*WORD_W +: WORD_W];
    end
  end

  assign word_valid = (state_reg == SEND);
  assign busy       = (state_reg == SEND);
  assign word_last  = word_valid && (idx_reg == LAST_IDX);
  assign word_out   = word_valid ? word_arr[idx_reg] : '0;
  assign overflow   = ovf_reg;

  assign xfer      = word_valid & word_ready;
  assign last_xfer = xfer && (idx_reg == LAST_IDX);

  // Next-state logic: capture, word advance, chaining and overflow.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    blk_next   = blk_reg;
    ovf_next   = ovf_reg;
    ovf_event  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          blk_next   = blk_in;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          idx_next = '0;
          if (capture) blk_next   = blk_in;
          else         state_next = IDLE;
        end else if (xfer) begin
          idx_next = idx_reg + IDX_W'(1);
        end
        // A new block with nowhere to go is lost.
        if (capture && !last_xfer) ovf_event = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Setting beats clearing when both happen together.
    if (clr_ovf)   ovf_next = 1'b0;
    if (ovf_event) ovf_next = 1'b1;
  end

  // State, index, holding block and sticky overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      blk_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      blk_reg   <= blk_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer; runs both word orders side by side.
module tb_aes_out_serializer;

  localparam logic [127:0] BLK_A = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BLK_C = 128'h00000000000000000000000000000001;
  localparam logic [31:0]  W0 = 32'h3925841d;
  localparam logic [31:0]  W1 = 32'h02dc09fb;
  localparam logic [31:0]  W2 = 32'hdc118597;
  localparam logic [31:0]  W3 = 32'h196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         done = 1'b0;
  logic         word_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [127:0] blk_in = '0;
  logic [31:0]  wo0, wo1;
  logic         v0, v1, l0, l1, b0, b1, o0, o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_out_serializer #(.LSW_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .done(done), .blk_in(blk_in),
    .word_ready(word_ready), .clr_ovf(clr_ovf),
    .word_out(wo0), .word_valid(v0), .word_last(l0), .busy(b0), .overflow(o0)
  );

  aes_out_serializer #(.LSW_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .done(done), .blk_in(blk_in),
    .word_ready(word_ready), .clr_ovf(clr_ovf),
    .word_out(wo1), .word_valid(v1), .word_last(l1), .busy(b1), .overflow(o1)
  );

  typedef struct {
    logic         d, r, c;
    logic [127:0] blk;
    logic         ev, el, eb, eo;
    logic [31:0]  ew0, ew1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic d, input logic r, input logic c, input logic [127:0] blk,
                     input logic ev, input logic el, input logic eb, input logic eo,
                     input logic [31:0] ew0, input logic [31:0] ew1);
    vec_t v;
    v.d = d; v.r = r; v.c = c; v.blk = blk;
    v.ev = ev; v.el = el; v.eb = eb; v.eo = eo; v.ew0 = ew0; v.ew1 = ew1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp0 [4];
    logic [31:0] exp1 [4];
    bit          pat [16];
    int          n;
    int          xfers;

    exp0 = '{W0, W1, W2, W3};
    exp1 = '{W3, W2, W1, W0};
    pat  = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    // Reset state
    tick();
    tick();
    chk("rst_valid", v0, 0);
    chk("rst_word", wo0, 0);
    chk("rst_last", l0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_ovf", o0, 0);
    rst = 1'b1;
    tick();

    // Basic order
    add(1,1,0,BLK_A, 1,0,1,0, W0,W3);
    add(0,1,0,BLK_A, 1,0,1,0, W1,W2);
    add(0,1,0,BLK_A, 1,0,1,0, W2,W1);
    add(0,1,0,BLK_A, 1,1,1,0, W3,W0);
    add(0,1,0,BLK_A, 0,0,0,0, 0,0);
    add(0,1,0,BLK_A, 0,0,0,0, 0,0);
    // Back-to-back: new block on the final transfer
    add(1,1,0,BLK_A, 1,0,1,0, W0,W3);
    add(0,1,0,BLK_A, 1,0,1,0, W1,W2);
    add(0,1,0,BLK_A, 1,0,1,0, W2,W1);
    add(0,1,0,BLK_A, 1,1,1,0, W3,W0);
    add(1,1,0,BLK_C, 1,0,1,0, 32'h0,32'h1);
    add(0,1,0,BLK_C, 1,0,1,0, 32'h0,32'h0);
    add(0,1,0,BLK_C, 1,0,1,0, 32'h0,32'h0);
    add(0,1,0,BLK_C, 1,1,1,0, 32'h1,32'h0);
    add(0,1,0,BLK_C, 0,0,0,0, 0,0);
    // Overflow: dropped rise mid-block, clear, clear colliding with a drop
    add(1,1,0,BLK_A, 1,0,1,0, W0,W3);
    add(0,1,0,BLK_A, 1,0,1,0, W1,W2);
    add(1,1,0,BLK_C, 1,0,1,1, W2,W1);
    add(0,1,0,BLK_C, 1,1,1,1, W3,W0);
    add(0,1,0,BLK_C, 0,0,0,1, 0,0);
    add(0,1,0,BLK_C, 0,0,0,1, 0,0);
    add(1,1,0,BLK_A, 1,0,1,1, W0,W3);
    add(0,1,1,BLK_A, 1,0,1,0, W1,W2);
    add(1,1,0,BLK_C, 1,0,1,1, W2,W1);
    add(0,1,0,BLK_C, 1,1,1,1, W3,W0);
    add(1,0,1,BLK_C, 1,1,1,1, W3,W0);
    add(0,1,0,BLK_C, 0,0,0,1, 0,0);
    add(0,1,1,BLK_C, 0,0,0,0, 0,0);
    // Level done held for 10 cycles
    add(1,1,0,BLK_A, 1,0,1,0, W0,W3);
    add(1,1,0,BLK_A, 1,0,1,0, W1,W2);
    add(1,1,0,BLK_A, 1,0,1,0, W2,W1);
    add(1,1,0,BLK_A, 1,1,1,0, W3,W0);
    for (int i = 0; i < 6; i++) add(1,1,0,BLK_A, 0,0,0,0, 0,0);
    add(0,1,0,BLK_A, 0,0,0,0, 0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      done = vecs[i].d; word_ready = vecs[i].r; clr_ovf = vecs[i].c; blk_in = vecs[i].blk;
      tick();
      $display("vec %0d: done=%0b rdy=%0b clr=%0b -> valid=%0b last=%0b busy=%0b ovf=%0b w0=%08h w1=%08h",
               i, vecs[i].d, vecs[i].r, vecs[i].c, v0, l0, b0, o0, wo0, wo1);
      chk($sformatf("vec%0d_valid0", i), v0, vecs[i].ev);
      chk($sformatf("vec%0d_valid1", i), v1, vecs[i].ev);
      chk($sformatf("vec%0d_last", i), l0, vecs[i].el);
      chk($sformatf("vec%0d_busy", i), b0, vecs[i].eb);
      chk($sformatf("vec%0d_ovf", i), o0, vecs[i].eo);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_word0", i), wo0, vecs[i].ew0);
        chk($sformatf("vec%0d_word1", i), wo1, vecs[i].ew1);
      end
    end
    clr_ovf = 1'b0;

    // Backpressure with ready pattern 0,1,0,0,1,...
    done = 1'b1; word_ready = 1'b0; blk_in = BLK_A;
    tick();
    done = 1'b0;
    n = 0;
    xfers = 0;
    for (int i = 0; i < 16; i++) begin
      if (n < 4) begin
        chk($sformatf("bp%0d_valid", i), v1, 1);
        chk($sformatf("bp%0d_word1", i), wo1, exp1[n]);
        chk($sformatf("bp%0d_word0", i), wo0, exp0[n]);
        chk($sformatf("bp%0d_last", i), l1, (n == 3));
      end else begin
        chk($sformatf("bp%0d_idle", i), v1, 0);
      end
      word_ready = pat[i];
      if (v1 && pat[i]) begin
        $display("bp transfer %0d: word=%08h", xfers, wo1);
        n++;
        xfers++;
      end
      tick();
    end
    chk("bp_xfers", xfers, 4);
    chk("bp_busy", b1, 0);

    // Asynchronous reset mid-block, with done held high through release
    done = 1'b1; word_ready = 1'b1; blk_in = BLK_A;
    tick();
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    chk("rs_pre_ovf", o0, 1);
    chk("rs_pre_valid", v0, 1);
    #2;
    rst = 1'b0;
    #1;
    $display("reset asserted: valid=%0b word=%08h busy=%0b ovf=%0b", v0, wo0, b0, o0);
    chk("rs_valid", v0, 0);
    chk("rs_word0", wo0, 0);
    chk("rs_word1", wo1, 0);
    chk("rs_last", l0, 0);
    chk("rs_busy", b0, 0);
    chk("rs_ovf", o0, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rs_hold%0d_valid", i), v0, 0);
      chk($sformatf("rs_hold%0d_busy", i), b0, 0);
    end
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      $display("post-reset word %0d: %08h last=%0b", k, wo0, l0);
      chk($sformatf("rs_w%0d_valid", k), v0, 1);
      chk($sformatf("rs_w%0d_word", k), wo0, exp0[k]);
      chk($sformatf("rs_w%0d_last", k), l0, (k == 3));
      tick();
    end
    chk("rs_end_busy", b0, 0);
    chk("rs_end_ovf", o0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
